bcd_to_binary_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the binary-to-BCD path that drives HEX0..HEX2.
- Takes a DIGITS-digit packed BCD word (switch entry on the DE2 board) and returns its binary value using reverse double-dabble: shift right one bit per clock, then subtract 3 from each BCD digit that is >= 8.
- Uses a start/busy/done handshake.
- Flags invalid digits (>9) and results that do not fit in BIN_W bits.

---
 rtl/bcd_to_binary_seq_pkg.sv | 19 +
 rtl/bcd_to_binary_seq_sub3.sv | 15 +
 rtl/bcd_to_binary_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

    // Default sizing; the top module recomputes widths from its own parameters.
    localparam int unsigned DIGITS_DEFAULT = 3;
    localparam int unsigned BIN_W_DEFAULT  = 8;
    localparam int unsigned BCD_W          = 4 * DIGITS_DEFAULT;
    localparam int unsigned CNT_W          = $clog2(BIN_W_DEFAULT + 1);

    // Largest legal BCD digit value.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_to_binary_seq_sub3.sv
// Reverse double-dabble digit correction: subtract 3 from a digit that is >= 8.
module bcd_sub3 (
    input  logic [3:0] value,
    output logic [3:0] result
);

    // A digit reaching 8 after a right shift carried in a half-ten; remove the excess.
    always_comb begin
        result = value;
        if (value >= 4'd8) begin
            result = value - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
module bcd_to_binary_seq
    import bcd_to_binary_seq_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEFAULT,
    parameter int unsigned BIN_W  = BIN_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  ovf,
    output logic                  err
);

    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned CW   = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    state_t              state;
    logic [DW-1:0]       bcd_sr;
    logic [BIN_W-1:0]    bin_sr;
    logic [CW-1:0]       cnt;

    logic [DW+BIN_W-1:0] cat_shift;
    logic [DW-1:0]       bcd_shift;
    logic [DW-1:0]       bcd_adj;
    logic [BIN_W-1:0]    bin_shift;
    logic                bad_digit;

    // Combined register shifted right by one; the BCD half then gets per-digit correction.
    always_comb begin
        cat_shift = {bcd_sr, bin_sr} >> 1;
        bcd_shift = cat_shift[DW+BIN_W-1 -: DW];
        bin_shift = cat_shift[BIN_W-1:0];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_sub3
        bcd_sub3 u_sub3 (
            .value  (bcd_shift[4*g +: 4]),
            .result (bcd_adj[4*g +: 4])
        );
    end

    // Flag any operand digit outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > DIGIT_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Control FSM, counter, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            bcd_sr  <= '0;
            bin_sr  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        bcd_sr <= bcd_in;
                        bin_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        ovf    <= 1'b0;
                        err    <= bad_digit;
                        if (bad_digit) begin
                            bin_out <= '0;
                            state   <= StDone;
                        end else begin
                            state <= StConv;
                        end
                    end
                end
                StConv: begin
                    bcd_sr <= bcd_adj;
                    bin_sr <= bin_shift;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bin_out <= bin_shift;
                        ovf     <= |bcd_adj;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    // Invalid operands arrive here with done low; they pulse done one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
